piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts WIDTH-bit words through a valid/ready handshake and shifts them out one bit per clock with framing strobes.
- A one-word holding buffer lets back-to-back words stream with no idle gap between frames.
- Sits downstream of the team's parallel register stages and drives a serial link whose receiver is a serial-in/parallel-out block.

Parameters:
- WIDTH, 4, bits per word; legal range is 2 or more.
- MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pi  input  WIDTH  parallel word; sampled only on an accepting edge.
- pi_valid  input  1  pi holds a word to send.
- pi_ready  output  1  block can accept a word this cycle.
- so  output  1  serial data bit.
- so_valid  output  1  so carries a valid bit this cycle.
- so_last  output  1  so is the final bit of the current word.
- busy  output  1  a frame is shifting or the holding buffer is occupied.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; it is sampled on the rising clk edge.
- Reset values:
  - state=IDLE, shift reg=0, bit counter=0, hold buffer=0, hfull=0.
  - so=0, so_valid=0, so_last=0, busy=0.
  - pi_ready is forced to 0 while rst=1 and is 1 in the first cycle after rst deasserts.
- Outputs are driven only from registers (no combinational path from pi or pi_valid):
  - pi_ready = !hfull && !rst.
  - so_valid = (state==SHIFT).
  - so_last = so_valid && (cnt==WIDTH-1).
  - so = shift reg output bit when SHIFT, else 0.
  - busy = so_valid || hfull.
- Accept: a word is accepted when pi_valid && pi_ready at a rising edge. pi may change freely on any other cycle.
- States: IDLE, SHIFT.
- IDLE + accept:
  - Load shift reg from pi, cnt=0, go to SHIFT.
  - First bit appears on so in the cycle after the accepting edge (latency 1).
  - so_valid stays high for exactly WIDTH cycles per word.
- SHIFT, cnt<WIDTH-1:
  - Each edge shifts by one (left if MSB_FIRST, else right), zero-fill, cnt+1.
  - An accept here writes pi into the hold buffer and sets hfull=1.
- SHIFT, cnt==WIDTH-1 (last-bit cycle), priority order:
  - (a) hfull=1: load shift reg from hold buffer, clear hfull, cnt=0, stay in SHIFT.
  - (b) hfull=0 and accept this cycle: load shift reg directly from pi (bypass), cnt=0, stay in SHIFT.
  - (c) otherwise: go to IDLE, cnt=0.
  - In (a) and (b) the next word's first bit follows the last bit with no gap.
- hfull=1 means pi_ready=0. A word presented while the buffer is full is not accepted and must be held by the source; it is never dropped or overwritten.
- Counter width is clog2(WIDTH) and it never exceeds WIDTH-1.
- Reset mid-frame: the next edge aborts the current frame and discards the hold buffer. No partial word and no so_last is emitted after reset.
- pi_valid while rst=1 has no effect.

Test Plan (WIDTH=4, MSB_FIRST=1 unless stated):
1. Hold rst=1 for 3 cycles with pi_valid=1 -> so_valid=so_last=busy=0 and pi_ready=0 throughout; pi_ready=1 in the first cycle after release.
2. Single word: pi=4'b1010 accepted at edge N, then pi_valid=0 -> so=1,0,1,0 with so_valid=1 in cycles N+1..N+4; so_last=1 only in N+4; so_valid=0 and busy=0 from N+5.
3. Back-to-back: pi=1010 at edge N, pi=1111 presented from N+1 -> 1111 goes to the hold buffer and pi_ready=0 until the last-bit cycle of 1010. so is 1,0,1,0,1,1,1,1 over 8 contiguous so_valid cycles, with so_last in cycles 4 and 8.
4. Backpressure: 1010 shifting, 1111 buffered, 0111 held on pi with pi_valid=1 -> 0111 is not accepted until pi_ready rises in the first bit-cycle of 1111. Output stream is 1010,1111,0111 with no gap and no loss.
5. Bypass: only 1010 in flight; 0000 presented exactly in its so_last cycle -> accepted directly, so=0,0,0,0 follows with no gap, hfull stays 0.
6. Reset mid-frame: 1010 accepted and 1111 buffered; assert rst after 2 bits have shifted -> so_valid=0 and busy=0 at the next cycle; 1111 is never transmitted. Separate build with MSB_FIRST=0 and pi=4'b0111 -> so=1,1,1,0.

Source files
------------

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in, serial-out transmitter. Accepts WIDTH-bit words
//                over a valid/ready handshake and shifts them out one bit per
//                clock with so_valid / so_last framing. A one-word holding
//                buffer lets consecutive words stream without idle gaps.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    // Bit counter only ever needs to reach WIDTH-1.
    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    localparam logic [0:0]     c_IDLE  = 1'b0;
    localparam logic [0:0]     c_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hfull;

    logic             w_accept;
    logic             w_shifting;
    logic             w_last_bit;
    logic             w_sbit;
    logic [WIDTH-1:0] w_shift_next;

    // Bit order selection: the outgoing bit sits at one end of the shift
    // register and the register moves toward that end, zero-filling behind.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sbit       = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_sbit       = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // Handshake and framing decode. pi_ready depends only on the hold-buffer
    // flag and reset, never on pi or pi_valid.
    assign pi_ready   = !r_hfull && !rst;
    assign w_accept   = pi_valid && pi_ready;
    assign w_shifting = (r_state == c_SHIFT);
    assign w_last_bit = (r_cnt == c_LAST);

    assign so_valid = w_shifting;
    assign so_last  = w_shifting && w_last_bit;
    assign so       = w_shifting ? w_sbit : 1'b0;
    assign busy     = w_shifting || r_hfull;

    // Frame sequencing: load, shift, refill from hold buffer or bypass from pi.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_hfull <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_shift <= pi;
                        r_cnt   <= '0;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (!w_last_bit) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + CW'(1);
                        // Mid-frame arrivals park in the hold buffer.
                        if (w_accept) begin
                            r_hold  <= pi;
                            r_hfull <= 1'b1;
                        end
                    end else if (r_hfull) begin
                        // Buffered word wins; pi_ready is low so no accept.
                        r_shift <= r_hold;
                        r_hfull <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        // Word offered in the last-bit cycle goes straight in.
                        r_shift <= pi;
                        r_cnt   <= '0;
                    end else begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer (WIDTH=4), MSB-first
//                and LSB-first instances sharing one stimulus stream, checked
//                against a bit-queue reference model plus literal sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic [W-1:0] pi       = '0;
    logic         pi_valid = 1'b1;

    logic pi_ready_m, so_m, so_valid_m, so_last_m, busy_m;
    logic pi_ready_l, so_l, so_valid_l, so_last_l, busy_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid), .pi_ready(pi_ready_m),
        .so(so_m), .so_valid(so_valid_m), .so_last(so_last_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .pi(pi), .pi_valid(pi_valid), .pi_ready(pi_ready_l),
        .so(so_l), .so_valid(so_valid_l), .so_last(so_last_l), .busy(busy_l)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: every accepted word becomes WIDTH queued bits; one
    // bit leaves per clock while anything is queued. The hold buffer is
    // occupied exactly when more than one word's worth of bits is pending.
    // ------------------------------------------------------------------
    bit q_m[$];
    bit q_l[$];
    bit q_last[$];
    bit model_on = 1'b0;
    bit mdl_acc;

    function automatic bit exp_ready();
        return !rst && (q_last.size() <= W);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_m.delete();
            q_l.delete();
            q_last.delete();
        end else begin
            mdl_acc = pi_valid && (q_last.size() <= W);
            if (q_last.size() > 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
                void'(q_last.pop_front());
            end
            if (mdl_acc) begin
                for (int i = 0; i < W; i++) begin
                    q_m.push_back(pi[W-1-i]);
                    q_l.push_back(pi[i]);
                    q_last.push_back(i == W-1);
                end
            end
        end
    end

    bit cmp_v;
    always @(negedge clk) begin
        if (model_on) begin
            cmp_v = (q_last.size() > 0);
            check("mdl.so_valid_m", so_valid_m, cmp_v);
            check("mdl.so_valid_l", so_valid_l, cmp_v);
            check("mdl.so_last_m",  so_last_m,  cmp_v ? q_last[0] : 1'b0);
            check("mdl.so_last_l",  so_last_l,  cmp_v ? q_last[0] : 1'b0);
            check("mdl.so_m",       so_m,       cmp_v ? q_m[0] : 1'b0);
            check("mdl.so_l",       so_l,       cmp_v ? q_l[0] : 1'b0);
            check("mdl.busy_m",     busy_m,     cmp_v);
            check("mdl.busy_l",     busy_l,     cmp_v);
            check("mdl.pi_ready_m", pi_ready_m, exp_ready());
            check("mdl.pi_ready_l", pi_ready_l, exp_ready());
        end
    end

    // ------------------------------------------------------------------
    // Directed literal sequences, then randomized traffic.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic b, input logic l);
        check({name, ".so_valid"}, so_valid_m, v);
        check({name, ".so"},       so_m,       b);
        check({name, ".so_last"},  so_last_m,  l);
    endtask

    logic [7:0] stream;
    logic [3:0] lsb_exp;
    bit         acc;

    initial begin
        // 1: reset held with pi_valid high
        pi = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            model_on = 1'b1;
            expect_out("t1", 1'b0, 1'b0, 1'b0);
            check("t1.busy", busy_m, 1'b0);
            check("t1.pi_ready", pi_ready_m, 1'b0);
        end
        rst = 1'b0;
        pi_valid = 1'b0;
        #1;
        check("t1.pi_ready_release", pi_ready_m, 1'b1);

        // 2: single word 1010
        pi = 4'b1010; pi_valid = 1'b1;
        tick();
        pi_valid = 1'b0;
        stream = 8'b1010_0000;
        for (int i = 0; i < 4; i++) begin
            expect_out("t2", 1'b1, stream[7-i], i == 3);
            tick();
        end
        expect_out("t2.end", 1'b0, 1'b0, 1'b0);
        check("t2.busy_end", busy_m, 1'b0);

        // 3: back-to-back 1010 then 1111 through the hold buffer
        pi = 4'b1010; pi_valid = 1'b1;
        tick();
        pi = 4'b1111;
        stream = 8'b1010_1111;
        for (int i = 0; i < 8; i++) begin
            expect_out("t3", 1'b1, stream[7-i], (i == 3) || (i == 7));
            if (i >= 1 && i <= 4) check("t3.pi_ready", pi_ready_m, i == 4);
            tick();
            if (i == 0) pi_valid = 1'b0;
        end
        expect_out("t3.end", 1'b0, 1'b0, 1'b0);

        // 5: bypass - 0000 offered exactly in the so_last cycle of 1010
        pi = 4'b1010; pi_valid = 1'b1;
        tick();
        pi_valid = 1'b0;
        stream = 8'b1010_0000;
        for (int i = 0; i < 8; i++) begin
            expect_out("t5", 1'b1, stream[7-i], (i == 3) || (i == 7));
            if (i >= 4) check("t5.pi_ready", pi_ready_m, 1'b1);
            if (i == 3) begin pi = 4'b0000; pi_valid = 1'b1; end
            tick();
            if (i == 3) pi_valid = 1'b0;
        end
        expect_out("t5.end", 1'b0, 1'b0, 1'b0);

        // 6: reset mid-frame discards in-flight and buffered words
        pi = 4'b1010; pi_valid = 1'b1;
        tick();
        pi = 4'b1111;
        expect_out("t6.b0", 1'b1, 1'b1, 1'b0);
        tick();
        pi_valid = 1'b0;
        expect_out("t6.b1", 1'b1, 1'b0, 1'b0);
        check("t6.hfull_busy", busy_m, 1'b1);
        rst = 1'b1;
        tick();
        expect_out("t6.rst", 1'b0, 1'b0, 1'b0);
        check("t6.busy_rst", busy_m, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out("t6.after", 1'b0, 1'b0, 1'b0);
            check("t6.busy_after", busy_m, 1'b0);
        end

        // LSB-first instance: 0111 -> 1,1,1,0
        pi = 4'b0111; pi_valid = 1'b1;
        lsb_exp = 4'b1110;
        tick();
        pi_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("lsb.so_valid", so_valid_l, 1'b1);
            check("lsb.so", so_l, lsb_exp[3-i]);
            check("lsb.so_last", so_last_l, i == 3);
            tick();
        end
        check("lsb.end", so_valid_l, 1'b0);

        // Randomized traffic with source-held backpressure and sporadic reset
        for (int c = 0; c < 4000; c++) begin
            acc = pi_valid && pi_ready_m;
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if (acc || !pi_valid) begin
                pi_valid = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 85 : 40));
                pi       = W'($urandom);
            end
        end
        pi_valid = 1'b0;
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
